uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Transmit stage directly downstream of the UART TX FIFO. Pops one byte at a time from the FIFO read side and serializes it onto the tx line as an async UART frame: start bit, 5-8 data bits LSB first, optional parity, and 1 or 2 stop bits. Bit timing comes from an external oversampled baud tick.

Parameters:
DATA_WIDTH, 8, FIFO word width; data bits above cfg length are ignored.
OVERSAMPLE, 16, baud_tick pulses per bit period (>=2).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
baud_tick  input  1  one-clk pulse, OVERSAMPLE per bit period
tx_en  input  1  allow new frames to start
cfg_data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity_en  input  1  insert parity bit
cfg_parity_odd  input  1  1=odd, 0=even parity
cfg_stop2  input  1  1=two stop bits, 0=one
fifo_empty  input  1  TX FIFO empty flag
fifo_rd_data  input  DATA_WIDTH  FIFO head word, first-word-fall-through, valid while !fifo_empty
fifo_rd  output  1  one-clk pop strobe to FIFO
tx  output  1  serial line, idles high
tx_busy  output  1  frame in progress
frame_done  output  1  one-clk pulse at end of last stop bit

Behaviour:
- Reset (rst=0, async): tx=1, tx_busy=0, fifo_rd=0, frame_done=0, state=IDLE, counters cleared. Reset mid-frame aborts the frame; tx returns high immediately. The FIFO is not popped again.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a clk edge with tx_en=1 and fifo_empty=0:
  - latch fifo_rd_data into shift_reg and latch all cfg_* into frame config;
  - drive fifo_rd=1 for exactly one clk;
  - tx<=0, state<=START, tick_cnt<=0, tx_busy<=1.
  - Otherwise stay in IDLE with tx=1.
- Bit timing: tick_cnt counts baud_tick. A bit ends on the baud_tick where tick_cnt==OVERSAMPLE-1; tick_cnt then wraps to 0 and the next bit value is driven on that same edge.
  - The start bit's first partial tick interval depends on the phase of baud_tick. Up to 1 tick of jitter is allowed.
- START -> DATA: tx<=shift_reg[0]; bit_cnt<=0.
- DATA: on each bit end, shift right and drive the next LSB. After bit_cnt==N-1 (N from the latched cfg):
  - go to PARITY if parity is enabled, else to STOP with tx<=1.
- PARITY: tx = XOR of the N data bits, inverted when parity_odd. On bit end go to STOP with tx<=1.
- STOP: 1 or 2 bit periods of tx=1. On the final bit end:
  - frame_done<=1 for one clk;
  - state<=IDLE, tx_busy<=0.
- Back-to-back frames: the next frame is decided in IDLE, so there is a 1-clk gap (tx stays 1) between stop end and the next start.
- Config changes and tx_en deassertion mid-frame do not affect the current frame. tx_en=0 only blocks new starts.
- fifo_rd is never asserted while fifo_empty=1 (no underflow generated by this block).
- Unused high data bits (N<DATA_WIDTH) are never transmitted.

Decomposition:
- uart_pkg holds:
  - tx_state_e enum;
  - cfg_data_bits encoding constants and a function data_bits_len(cfg) returning 5..8;
  - parity helper function.
- One sub-module, uart_bit_timer: the tick counter. Inputs clk, rst, baud_tick, clear; output bit_end. Width $clog2(OVERSAMPLE).

Test Plan:
- FIFO holds 0x55, 8N1, OVERSAMPLE=16 -> one fifo_rd pulse; tx = 0,1,0,1,0,1,0,1,0,1 then stop; each bit 16 baud_ticks; frame_done after 10 bit periods.
- 0xA3, 7 bits, even parity, 2 stop -> data 1,1,0,0,0,1,0, parity 1 (three ones), stop 1,1; frame 11 bits long; bit 7 of the byte is never sent.
- fifo_empty=1 with tx_en=1 for 1000 clks -> fifo_rd never asserted, tx=1, tx_busy=0.
- Three bytes queued (0x00, 0xFF, 0x81), 8O1 -> three fifo_rd pulses; each frame separated by exactly 1 clk of idle-high; parity bits 1, 1, 1.
- rst pulled low during the DATA state of a frame -> tx=1 in the same cycle, tx_busy=0; after release with fifo_empty=1, no further pops.
- tx_en dropped and cfg_data_bits changed 00 mid-frame -> current 8-bit frame completes unchanged; no new frame starts until tx_en=1, and that frame uses 5 bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    // Serializer FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // cfg_data_bits encoding
    localparam logic [1:0] CFG_BITS_5 = 2'b00;
    localparam logic [1:0] CFG_BITS_6 = 2'b01;
    localparam logic [1:0] CFG_BITS_7 = 2'b10;
    localparam logic [1:0] CFG_BITS_8 = 2'b11;

    localparam int MAX_DATA_BITS = 8;

    // Number of data bits (5..8) selected by the cfg_data_bits field.
    function automatic logic [3:0] data_bits_len(input logic [1:0] cfg);
        logic [3:0] len;
        case (cfg)
            CFG_BITS_5: len = 4'd5;
            CFG_BITS_6: len = 4'd6;
            CFG_BITS_7: len = 4'd7;
            default:    len = 4'd8;
        endcase
        return len;
    endfunction

    // Parity over the low 'len' bits; odd=1 inverts the XOR so the total count of ones is odd.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [3:0] len,
                                        input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < int'(len)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: down-counts baud ticks and flags the tick that closes a bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] TC_LOAD = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q;

    // Terminal count is zero; a tick arriving at zero ends the bit and reloads.
    assign bit_end = baud_tick && !clear && (cnt_q == '0);

    // Counter: held at the reload value while cleared, otherwise one step per baud tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= TC_LOAD;
        end else if (clear) begin
            cnt_q <= TC_LOAD;
        end else if (baud_tick) begin
            if (cnt_q == '0) begin
                cnt_q <= TC_LOAD;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts out framed async data.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | line high, waiting for tx_en and a non-empty FIFO
//   ST_START  | driving the start bit (0)
//   ST_DATA   | shifting out N data bits, LSB first
//   ST_PARITY | driving the precomputed parity bit
//   ST_STOP   | driving one or two stop bits (1), then pulse frame_done
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  tx_en,
    input  logic [1:0]            cfg_data_bits,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_odd,
    input  logic                  cfg_stop2,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  frame_done
);

    tx_state_e state_q, state_d;

    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [2:0]               last_idx_q, last_idx_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic                     stop2_q, stop2_d;
    logic                     stop_cnt_q, stop_cnt_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;
    logic                     rd_q, rd_d;
    logic                     done_q, done_d;

    logic                     timer_clear;
    logic                     bit_end;
    logic [MAX_DATA_BITS-1:0] head_byte;

    // Only the low bits of the FIFO word can ever be transmitted.
    assign head_byte = MAX_DATA_BITS'(fifo_rd_data);

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .clear     (timer_clear),
        .bit_end   (bit_end)
    );

    // Next-state and registered-output decisions; frame config is frozen at start.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        last_idx_d  = last_idx_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        stop_cnt_d  = stop_cnt_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        rd_d        = 1'b0;
        done_d      = 1'b0;
        timer_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                tx_d        = 1'b1;
                busy_d      = 1'b0;
                if (tx_en && !fifo_empty) begin
                    shift_d    = head_byte;
                    last_idx_d = 3'(data_bits_len(cfg_data_bits) - 4'd1);
                    par_en_d   = cfg_parity_en;
                    par_bit_d  = parity_bit(head_byte, data_bits_len(cfg_data_bits), cfg_parity_odd);
                    stop2_d    = cfg_stop2;
                    rd_d       = 1'b1;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == last_idx_q) begin
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame and releases the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            last_idx_q <= 3'd7;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            rd_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            last_idx_q <= last_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            rd_q       <= rd_d;
            done_q     <= done_d;
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign fifo_rd    = rd_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: stimulus queues bytes and expected frames; a monitor decodes tx and compares.
module tb_uart_tx_serializer;

    localparam int OS = 16;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          baud_tick;
    logic          tx_en;
    logic [1:0]    cfg_data_bits;
    logic          cfg_parity_en;
    logic          cfg_parity_odd;
    logic          cfg_stop2;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd;
    logic          tx;
    logic          tx_busy;
    logic          frame_done;

    typedef struct {
        logic [11:0] bits;   // bits[0] = start bit, in transmit order
        int          nbits;
        bit          b2b;    // must start exactly one clk after previous frame_done
    } frame_t;

    frame_t      exp_q[$];
    logic [7:0]  fq[$];
    frame_t      cur;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int mon_cnt = 0;
    int last_done_cyc = -100;
    bit in_frame = 0;

    uart_tx_serializer #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk            (clk),
        .rst            (rst_n),
        .baud_tick      (baud_tick),
        .tx_en          (tx_en),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .fifo_empty     (fifo_empty),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd        (fifo_rd),
        .tx             (tx),
        .tx_busy        (tx_busy),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] bits, input int nbits, input bit b2b);
        frame_t f;
        f.bits  = bits;
        f.nbits = nbits;
        f.b2b   = b2b;
        exp_q.push_back(f);
    endtask

    task automatic push_byte(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty   = 1'b0;
        fifo_rd_data = fq[0];
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_ticks(input int min_ticks, input string name);
        int n = 0;
        while (!(in_frame && mon_cnt >= min_ticks) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(in_frame && mon_cnt >= min_ticks), 32'd1);
    endtask

    // Baud tick: one clk high every 4 clks.
    initial begin
        int div = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    // FIFO model: pop on the strobe, flag any pop of an empty FIFO.
    initial begin
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        forever begin
            @(negedge clk);
            if (fifo_rd === 1'b1) begin
                rd_cnt++;
                check("no_underflow", 32'(fq.size() != 0), 32'd1);
                if (fq.size() != 0) void'(fq.pop_front());
                fifo_empty   = (fq.size() == 0);
                fifo_rd_data = fifo_empty ? 8'h00 : fq[0];
            end
        end
    end

    // Monitor: decode frames off tx using baud tick counts since the start bit.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_frame = 0;
                continue;
            end
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1;
                mon_cnt  = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got start bit expected idle");
                    cur.bits  = '0;
                    cur.nbits = 0;
                    cur.b2b   = 0;
                end else begin
                    cur = exp_q.pop_front();
                    check("busy_at_start", 32'(tx_busy), 32'd1);
                    if (cur.b2b) check("b2b_gap_clks", 32'(cyc - last_done_cyc), 32'd1);
                end
            end
            if (in_frame) begin
                if (frame_done === 1'b1) begin
                    check("frame_len_ticks", 32'(mon_cnt), 32'(cur.nbits * OS));
                    check("busy_at_done", 32'(tx_busy), 32'd0);
                    check("tx_at_done", 32'(tx), 32'd1);
                    done_cnt++;
                    last_done_cyc = cyc;
                    in_frame = 0;
                end else begin
                    if (baud_tick) begin
                        if (mon_cnt % OS == OS / 2 && mon_cnt / OS < cur.nbits)
                            check($sformatf("bit%0d", mon_cnt / OS), 32'(tx), 32'(cur.bits[mon_cnt / OS]));
                        mon_cnt++;
                    end
                    if (mon_cnt > (cur.nbits + 1) * OS) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_done_timeout: got %0d ticks expected %0d", mon_cnt, cur.nbits * OS);
                        in_frame = 0;
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int  rd0;
        bit  bad_tx, bad_busy;

        rst_n          = 1'b0;
        tx_en          = 1'b0;
        cfg_data_bits  = 2'b11;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // 0x55, 8N1
        @(posedge clk); #2;
        tx_en = 1'b1;
        rd0 = rd_cnt;
        push_exp(12'(10'b1010101010), 10, 0);
        push_byte(8'h55);
        wait_done(1, "done_0x55");
        check("pops_0x55", 32'(rd_cnt - rd0), 32'd1);

        // 0xA3, 7E2: bit 7 must not appear
        @(posedge clk); #2;
        cfg_data_bits = 2'b10; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
        push_exp(12'(11'b11101000110), 11, 0);
        push_byte(8'hA3);
        wait_done(2, "done_0xA3");

        // Empty FIFO with tx_en high
        @(posedge clk); #2;
        rd0 = rd_cnt; bad_tx = 0; bad_busy = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1;
            if (tx_busy !== 1'b0) bad_busy = 1;
        end
        check("idle_pops", 32'(rd_cnt - rd0), 32'd0);
        check("idle_tx_low_seen", 32'(bad_tx), 32'd0);
        check("idle_busy_seen", 32'(bad_busy), 32'd0);

        // Three queued bytes, 8O1, back to back
        @(posedge clk); #2;
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_stop2 = 1'b0;
        rd0 = rd_cnt;
        push_exp(12'(11'b11000000000), 11, 0);
        push_exp(12'(11'b11111111110), 11, 1);
        push_exp(12'(11'b11100000010), 11, 1);
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h81);
        wait_done(3, "done_b2b_0");
        wait_done(4, "done_b2b_1");
        wait_done(5, "done_b2b_2");
        check("pops_b2b", 32'(rd_cnt - rd0), 32'd3);

        // Reset during DATA
        @(posedge clk); #2;
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        push_exp(12'(10'b1000011110), 10, 0);
        push_byte(8'h0F);
        wait_ticks(3 * OS + 4, "reach_data_state");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rd0 = rd_cnt;
        repeat (500) @(negedge clk);
        check("postrst_pops", 32'(rd_cnt - rd0), 32'd0);
        check("postrst_tx", 32'(tx), 32'd1);
        check("postrst_busy", 32'(tx_busy), 32'd0);

        // tx_en drop and cfg change mid-frame
        @(posedge clk); #2;
        tx_en = 1'b1;
        push_exp(12'(10'b1001111000), 10, 0);
        push_byte(8'h3C);
        wait_ticks(OS + 4, "reach_mid_frame");
        tx_en = 1'b0;
        cfg_data_bits = 2'b00;
        wait_done(6, "done_0x3C");
        @(posedge clk); #2;
        rd0 = rd_cnt;
        push_byte(8'hF2);
        repeat (300) @(negedge clk);
        check("txen_off_pops", 32'(rd_cnt - rd0), 32'd0);
        check("txen_off_busy", 32'(tx_busy), 32'd0);
        @(posedge clk); #2;
        push_exp(12'(7'b1100100), 7, 0);
        tx_en = 1'b1;
        wait_done(7, "done_0xF2_5bit");
        check("pops_0xF2", 32'(rd_cnt - rd0), 32'd1);

        repeat (20) @(negedge clk);
        check("exp_frames_left", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
